inst_fetch_unit: RTL and testbench
==================================

// Module: inst_fetch_unit
// PURPOSE
//   Program-counter and fetch stage that drives the instruction memory address and captures the
//   returned word into the IF/ID pipeline register for the decoder.
//   - Sits directly upstream of the instruction memory, whose read is combinational and word-addressed
//     (index = inst_addr[31:2]); also acts as the fetch->decode boundary.
//   - Handles stall, branch/jump redirect, pipeline flush and fetch faults.
// PARAMETERS
//   RESET_PC    32'h0000_0000  PC loaded on reset; must be word-aligned
//   IMEM_WORDS  256            instruction memory depth in 32-bit words; legal PC < IMEM_WORDS*4
//   NOP_INST    32'h0000_0013  instruction placed in IF/ID on bubble/flush (addi x0,x0,0)
// PORTS
//   clk             in   1   system clock, all state updates on rising edge
//   rst             in   1   synchronous, active-high reset
//   inst_addr       out  32  fetch address to instruction memory (= PC register)
//   instruction     in   32  word returned combinationally by instruction memory for inst_addr
//   stall           in   1   hold PC and IF/ID contents this cycle
//   redirect_valid  in   1   taken branch/jump this cycle
//   redirect_pc     in   32  redirect target
//   if_valid        out  1   IF/ID holds a real instruction
//   if_pc           out  32  PC of instruction in IF/ID
//   if_pc_plus4     out  32  if_pc + 4 (mod 2^32)
//   if_inst         out  32  instruction in IF/ID
//   fetch_fault     out  1   sticky: fetch halted on illegal address
// BEHAVIOUR
//   States: BOOT, RUN, FAULT (2-bit encoded). Event priority at each edge: rst > FAULT hold > redirect > stall > advance.
//   Reset (rst=1 at edge, from any state; abandons any in-flight fetch):
//     pc=RESET_PC, if_valid=0, if_pc=0, if_pc_plus4=0, if_inst=NOP_INST, fetch_fault=0, state=BOOT.
//   BOOT: lasts one cycle; IF/ID stays bubble; pc unchanged; -> RUN. redirect/stall ignored in BOOT.
//   RUN, advance (no redirect, no stall):
//     IF/ID <= {1, pc, pc+4, instruction}; pc <= pc+4.
//     Fetch-to-IF/ID latency is one cycle.
//   RUN, stall=1, no redirect: pc and all IF/ID outputs hold their values.
//   RUN, redirect_valid=1 (stall is ignored):
//     IF/ID <= bubble (if_valid=0, if_inst=NOP_INST, if_pc/if_pc_plus4 hold); pc <= redirect_pc.
//     The instruction presented this cycle is discarded (flush).
//   Address checks:
//     redirect_pc[1:0]!=0 or redirect_pc >= IMEM_WORDS*4
//       -> pc unchanged, IF/ID bubble, fetch_fault<=1, state=FAULT.
//     Sequential pc+4 >= IMEM_WORDS*4 (including 32-bit wrap to 0)
//       -> current word is still captured normally; pc holds; fetch_fault<=1; state=FAULT.
//   FAULT: pc holds; IF/ID <= bubble on first FAULT cycle, then holds; fetch_fault=1.
//     stall/redirect ignored; exit only via rst.
//   Arithmetic: 32-bit unsigned, pc+4 truncated mod 2^32.
//   inst_addr is always the registered pc, never combinational from inputs.
//   Invariant: inst_addr[1:0]==2'b00 whenever fetch_fault==0.
// TESTING
//   1. rst 2 cycles, then run 4 cycles
//      -> inst_addr 0,4,8,12; if_valid 0 in first post-reset cycle; then if_pc 0,4,8 with matching mem words.
//   2. stall=1 for 3 cycles at pc=8
//      -> inst_addr stays 8; if_pc/if_inst frozen at pc 4 contents; resume yields if_pc=8 next.
//   3. redirect_valid=1, redirect_pc=0x40 at pc=0x10 (stall=1 same cycle)
//      -> next cycle inst_addr=0x40, if_valid=0, if_inst=0x00000013; following cycle if_pc=0x40.
//   4. redirect_pc=0x42 -> fetch_fault=1, inst_addr frozen, if_valid=0 until rst; rst clears fault, inst_addr=RESET_PC.
//   5. IMEM_WORDS=4, run from 0 -> pcs 0,4,8,12 fetched; after 12 captured, fetch_fault=1, inst_addr stays 12.
//   6. rst asserted mid-stream with redirect_valid=1 -> reset wins: inst_addr=RESET_PC, if_valid=0, state BOOT.

Source files
------------

// File: rtl/inst_fetch_unit.sv
// Program counter and fetch stage: drives the instruction memory address and
// registers the returned word into the IF/ID boundary for the decoder.
module inst_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_WORDS = 256,
    parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] inst_addr,
    input  logic [31:0] instruction,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus4,
    output logic [31:0] if_inst,
    output logic        fetch_fault
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } state_e;

    // 33-bit so that a 4 GiB memory limit and the pc+4 carry both compare correctly
    localparam logic [32:0] PC_LIMIT = 33'(IMEM_WORDS) << 2;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        vld_q, vld_d;
    logic [31:0] ifpc_q, ifpc_d;
    logic [31:0] ifpc4_q, ifpc4_d;
    logic [31:0] ifinst_q, ifinst_d;
    logic        fault_q, fault_d;

    logic [32:0] seq_sum;
    logic        redir_bad;

    assign seq_sum   = {1'b0, pc_q} + 33'd4;
    assign redir_bad = (redirect_pc[1:0] != 2'b00) || ({1'b0, redirect_pc} >= PC_LIMIT);

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        vld_d    = vld_q;
        ifpc_d   = ifpc_q;
        ifpc4_d  = ifpc4_q;
        ifinst_d = ifinst_q;
        fault_d  = fault_q;

        unique case (state_q)
            BOOT: begin
                state_d = RUN;
            end
            RUN: begin
                if (redirect_valid) begin
                    // Flush: the word fetched this cycle is dropped, if_pc fields hold
                    vld_d    = 1'b0;
                    ifinst_d = NOP_INST;
                    if (redir_bad) begin
                        fault_d = 1'b1;
                        state_d = FAULT;
                    end else begin
                        pc_d = redirect_pc;
                    end
                end else if (!stall) begin
                    vld_d    = 1'b1;
                    ifpc_d   = pc_q;
                    ifpc4_d  = seq_sum[31:0];
                    ifinst_d = instruction;
                    // Last legal word is still delivered; pc parks on it
                    if (seq_sum >= PC_LIMIT) begin
                        fault_d = 1'b1;
                        state_d = FAULT;
                    end else begin
                        pc_d = seq_sum[31:0];
                    end
                end
            end
            FAULT: begin
                vld_d    = 1'b0;
                ifinst_d = NOP_INST;
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= BOOT;
            pc_q     <= RESET_PC;
            vld_q    <= 1'b0;
            ifpc_q   <= '0;
            ifpc4_q  <= '0;
            ifinst_q <= NOP_INST;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            vld_q    <= vld_d;
            ifpc_q   <= ifpc_d;
            ifpc4_q  <= ifpc4_d;
            ifinst_q <= ifinst_d;
            fault_q  <= fault_d;
        end
    end

    assign inst_addr   = pc_q;
    assign if_valid    = vld_q;
    assign if_pc       = ifpc_q;
    assign if_pc_plus4 = ifpc4_q;
    assign if_inst     = ifinst_q;
    assign fetch_fault = fault_q;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit: a full-size instance and a 4-word instance,
// each fed by a combinational memory model, checked through an expectation queue.
module tb_inst_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          sel;
        string       tag;
        logic        v;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] inst;
        logic [31:0] addr;
        logic        f;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    function automatic logic [31:0] memw(input logic [31:0] a);
        return 32'hC0DE_0000 | {16'h0000, a[15:0]};
    endfunction

    // DUT A: 256-word memory
    logic        rst_a, stall_a, rv_a;
    logic [31:0] rpc_a, addr_a, inst_a, ifpc_a, ifpc4_a, ifinst_a;
    logic        ifv_a, flt_a;
    assign inst_a = memw(addr_a);

    inst_fetch_unit #(.RESET_PC(32'h0), .IMEM_WORDS(256), .NOP_INST(NOP)) dut_a (
        .clk(clk), .rst(rst_a), .inst_addr(addr_a), .instruction(inst_a),
        .stall(stall_a), .redirect_valid(rv_a), .redirect_pc(rpc_a),
        .if_valid(ifv_a), .if_pc(ifpc_a), .if_pc_plus4(ifpc4_a),
        .if_inst(ifinst_a), .fetch_fault(flt_a)
    );

    // DUT B: 4-word memory for the sequential end-of-memory case
    logic        rst_b, stall_b, rv_b;
    logic [31:0] rpc_b, addr_b, inst_b, ifpc_b, ifpc4_b, ifinst_b;
    logic        ifv_b, flt_b;
    assign inst_b = memw(addr_b);

    inst_fetch_unit #(.RESET_PC(32'h0), .IMEM_WORDS(4), .NOP_INST(NOP)) dut_b (
        .clk(clk), .rst(rst_b), .inst_addr(addr_b), .instruction(inst_b),
        .stall(stall_b), .redirect_valid(rv_b), .redirect_pc(rpc_b),
        .if_valid(ifv_b), .if_pc(ifpc_b), .if_pc_plus4(ifpc4_b),
        .if_inst(ifinst_b), .fetch_fault(flt_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input bit sel, input string tag, input logic v, input logic [31:0] pc,
                        input logic [31:0] pc4, input logic [31:0] inst,
                        input logic [31:0] addr, input logic f);
        exp_t e;
        e.sel = sel; e.tag = tag; e.v = v; e.pc = pc; e.pc4 = pc4;
        e.inst = inst; e.addr = addr; e.f = f;
        q.push_back(e);
    endtask

    // Advance one clock, then pop the oldest expectation and compare the chosen DUT
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (q.size() == 0) begin
            n_cmp++;
            n_err++;
            $error("FAIL scoreboard_empty: got 0 entries expected 1");
        end else begin
            e = q.pop_front();
            if (!e.sel) begin
                chk({e.tag, ".valid"}, {31'd0, ifv_a}, {31'd0, e.v});
                chk({e.tag, ".if_pc"}, ifpc_a, e.pc);
                chk({e.tag, ".if_pc4"}, ifpc4_a, e.pc4);
                chk({e.tag, ".if_inst"}, ifinst_a, e.inst);
                chk({e.tag, ".addr"}, addr_a, e.addr);
                chk({e.tag, ".fault"}, {31'd0, flt_a}, {31'd0, e.f});
            end else begin
                chk({e.tag, ".valid"}, {31'd0, ifv_b}, {31'd0, e.v});
                chk({e.tag, ".if_pc"}, ifpc_b, e.pc);
                chk({e.tag, ".if_pc4"}, ifpc4_b, e.pc4);
                chk({e.tag, ".if_inst"}, ifinst_b, e.inst);
                chk({e.tag, ".addr"}, addr_b, e.addr);
                chk({e.tag, ".fault"}, {31'd0, flt_b}, {31'd0, e.f});
            end
        end
    endtask

    initial begin
        rst_a = 1'b1; stall_a = 1'b0; rv_a = 1'b0; rpc_a = '0;
        rst_b = 1'b1; stall_b = 1'b0; rv_b = 1'b0; rpc_b = '0;

        // Reset, boot bubble, sequential run
        push(0, "rst0", 0, 0, 0, NOP, 0, 0);                       tick();
        push(0, "rst1", 0, 0, 0, NOP, 0, 0);                       tick();
        rst_a = 1'b0;
        push(0, "boot", 0, 0, 0, NOP, 0, 0);                       tick();
        push(0, "run0", 1, 32'h0, 32'h4, memw(32'h0), 32'h4, 0);   tick();
        push(0, "run1", 1, 32'h4, 32'h8, memw(32'h4), 32'h8, 0);   tick();

        // Stall holds pc=8 and IF/ID at pc 4
        stall_a = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push(0, "stall", 1, 32'h4, 32'h8, memw(32'h4), 32'h8, 0);
            tick();
        end
        stall_a = 1'b0;
        push(0, "resume", 1, 32'h8, 32'hC, memw(32'h8), 32'hC, 0);   tick();
        push(0, "run3", 1, 32'hC, 32'h10, memw(32'hC), 32'h10, 0);   tick();

        // Redirect wins over stall; bubble then target
        rv_a = 1'b1; rpc_a = 32'h40; stall_a = 1'b1;
        push(0, "redir", 0, 32'hC, 32'h10, NOP, 32'h40, 0);          tick();
        rv_a = 1'b0; stall_a = 1'b0;
        push(0, "redir_tgt", 1, 32'h40, 32'h44, memw(32'h40), 32'h44, 0); tick();

        // Reset beats a concurrent redirect; BOOT ignores redirect
        rst_a = 1'b1; rv_a = 1'b1; rpc_a = 32'h80;
        push(0, "rst_mid", 0, 0, 0, NOP, 0, 0);                      tick();
        rst_a = 1'b0;
        push(0, "boot_ignr", 0, 0, 0, NOP, 0, 0);                    tick();
        rv_a = 1'b0;
        push(0, "post_boot", 1, 32'h0, 32'h4, memw(32'h0), 32'h4, 0); tick();

        // Misaligned redirect faults; fault is sticky and ignores inputs
        rv_a = 1'b1; rpc_a = 32'h42;
        push(0, "mis_fault", 0, 32'h0, 32'h4, NOP, 32'h4, 1);        tick();
        rpc_a = 32'h100; stall_a = 1'b1;
        for (int i = 0; i < 2; i++) begin
            push(0, "fault_hold", 0, 32'h0, 32'h4, NOP, 32'h4, 1);
            tick();
        end
        rst_a = 1'b1; rv_a = 1'b0; stall_a = 1'b0;
        push(0, "fault_rst", 0, 0, 0, NOP, 0, 0);                    tick();
        rst_a = 1'b0;
        push(0, "boot2", 0, 0, 0, NOP, 0, 0);                        tick();
        push(0, "run_b2", 1, 32'h0, 32'h4, memw(32'h0), 32'h4, 0);   tick();

        // Redirect to first out-of-range address
        rv_a = 1'b1; rpc_a = 32'h400;
        push(0, "range_fault", 0, 32'h0, 32'h4, NOP, 32'h4, 1);      tick();

        // Redirect to last legal word, then sequential fetch hits the end
        rst_a = 1'b1; rv_a = 1'b0;
        push(0, "rst3", 0, 0, 0, NOP, 0, 0);                         tick();
        rst_a = 1'b0;
        push(0, "boot3", 0, 0, 0, NOP, 0, 0);                        tick();
        rv_a = 1'b1; rpc_a = 32'h3FC;
        push(0, "redir_last", 0, 0, 0, NOP, 32'h3FC, 0);             tick();
        rv_a = 1'b0;
        push(0, "seq_end", 1, 32'h3FC, 32'h400, memw(32'h3FC), 32'h3FC, 1); tick();
        push(0, "seq_end_bub", 0, 32'h3FC, 32'h400, NOP, 32'h3FC, 1); tick();

        // Small memory: pcs 0..12 fetched, then fault with pc parked at 12
        rst_b = 1'b0;
        push(1, "b_boot", 0, 0, 0, NOP, 0, 0);                       tick();
        push(1, "b_run0", 1, 32'h0, 32'h4, memw(32'h0), 32'h4, 0);   tick();
        push(1, "b_run1", 1, 32'h4, 32'h8, memw(32'h4), 32'h8, 0);   tick();
        push(1, "b_run2", 1, 32'h8, 32'hC, memw(32'h8), 32'hC, 0);   tick();
        push(1, "b_last", 1, 32'hC, 32'h10, memw(32'hC), 32'hC, 1);  tick();
        push(1, "b_bub", 0, 32'hC, 32'h10, NOP, 32'hC, 1);           tick();
        rv_b = 1'b1; rpc_b = 32'h4;
        push(1, "b_hold", 0, 32'hC, 32'h10, NOP, 32'hC, 1);          tick();
        rv_b = 1'b0;

        n_cmp++;
        assert (q.size() == 0) else begin
            n_err++;
            $error("FAIL scoreboard_drain: got %0d entries expected 0", q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
